// File: rtl/ahb_lite_resp_mux.sv
// ahb_lite_resp_mux: AHB-Lite slave-to-master response mux with built-in default slave.
// Unmapped or multi-hot NONSEQ/SEQ transfers get a two-cycle ERROR and are counted.
module ahb_lite_resp_mux #(
    parameter int NUM_SLAVES    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [1:0]                       HTRANS,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HRESP,
    output logic                             HREADY,
    output logic [ERR_CNT_WIDTH-1:0]         ERR_CNT
);
    typedef enum logic [1:0] {IDLE = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic                  hsel_hot;
    logic                  unused_htrans;

    assign unused_htrans = HTRANS[0];
    assign hsel_hot      = $onehot(HSEL);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ERR_CNT <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (state_d == ERR1 && !(&ERR_CNT))
                ERR_CNT <= ERR_CNT + ERR_CNT_WIDTH'(1);
        end
    end

    // ERR1 always advances; otherwise the request is classified only on an HREADY edge
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (state_q == ERR1)
            state_d = ERR2;
        else if (HREADY) begin
            sel_d   = hsel_hot ? HSEL : '0;
            state_d = (!hsel_hot && HTRANS[1]) ? ERR1 : IDLE;
        end
    end

    // Any non-IDLE encoding behaves as an error cycle; only ERR1 stalls the bus
    always_comb begin
        HRDATA = '0;
        HRESP  = 1'b0;
        HREADY = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (sel_q[i]) begin
                HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                HRESP  = HRESP_S[i];
                HREADY = HREADYOUT_S[i];
            end
        if (state_q != IDLE) begin
            HRDATA = '0;
            HRESP  = 1'b1;
            HREADY = (state_q != ERR1);
        end
    end
endmodule
